perf_counter_bank: RTL and testbench

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 13 +
 rtl/perf_cnt_cell.sv | 56 +++++
 rtl/perf_counter_bank.sv | 116 +++++++++++
 tb/tb_perf_counter_bank.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
// Control FSM encoding and counter overflow modes.
package perf_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/perf_cnt_cell.sv
// One live counter with clear, increment, wrap/saturate mode
// and a sticky overflow flag.
module perf_cnt_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             at_max;

  assign at_max = &cnt_q;

  // Next value: clear beats increment; all-ones wraps or holds.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (at_max) begin
        ovf_d = 1'b1;
        cnt_d = (SAT_MODE == MODE_SAT) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus N_EV event counters with halt/resume
// control, freeze, snapshot shadows and a read mux.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int N_EV     = 4,
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = MODE_WRAP,
  localparam int RSW     = $clog2(N_EV + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             soft_clr,
  input  logic [N_EV-1:0]  ev,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             freeze,
  input  logic             snap_req,
  output logic             snap_ack,
  input  logic [RSW-1:0]   rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic [N_EV:0]    ovf,
  output logic             running
);

  state_e           state_q;
  state_e           state_d;
  logic             snap_ack_q;
  logic             snap_ack_d;
  logic             is_run;
  logic             gate;
  logic [N_EV:0]    inc;
  logic [CNT_W-1:0] live     [N_EV+1];
  logic [CNT_W-1:0] shadow_q [N_EV+1];
  logic [CNT_W-1:0] shadow_d [N_EV+1];

  assign is_run = (state_q == RUN);
  assign gate   = is_run & ~freeze;

  // The halt request cycle is not a counted cycle for C0.
  always_comb begin
    inc    = '0;
    inc[0] = gate & ~halt_req;
    inc[N_EV:1] = ev & {N_EV{gate}};
  end

  for (genvar i = 0; i <= N_EV; i++) begin : g_cell
    perf_cnt_cell #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE)
    ) u_cell (
      .clk  (clk),
      .clr_n(clr_n),
      .clr  (soft_clr),
      .inc  (inc[i]),
      .cnt  (live[i]),
      .ovf  (ovf[i])
    );
  end

  // Run/halt control; soft clear forces RUN, halt beats resume.
  always_comb begin
    state_d = state_q;
    if (soft_clr) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN:    if (halt_req) state_d = HALTED;
        HALTED: if (resume)   state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Shadow capture of pre-increment live values and ack pulse.
  always_comb begin
    snap_ack_d = snap_req & ~soft_clr;
    for (int i = 0; i <= N_EV; i++) begin
      shadow_d[i] = shadow_q[i];
      if (soft_clr) begin
        shadow_d[i] = '0;
      end else if (snap_req) begin
        shadow_d[i] = live[i];
      end
    end
  end

  // Control, ack and shadow registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= RUN;
      snap_ack_q <= 1'b0;
      for (int i = 0; i <= N_EV; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      snap_ack_q <= snap_ack_d;
      for (int i = 0; i <= N_EV; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  // Read mux; indices past the last channel return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i <= N_EV; i++) begin
      if (rd_sel == RSW'(i)) rd_data = shadow_q[i];
    end
  end

  assign snap_ack = snap_ack_q;
  assign running  = is_run;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: 8-bit wrap and saturate
// instances driven in parallel against a count-based model.
module tb_perf_counter_bank;

  localparam int N_EV = 4;

  logic       clk;
  logic       clr_n;
  logic       soft_clr;
  logic [3:0] ev;
  logic       halt_req;
  logic       resume;
  logic       freeze;
  logic       snap_req;
  logic [2:0] rd_sel;

  logic       ack_w, ack_s;
  logic [7:0] rd_w, rd_s;
  logic [4:0] ovf_w, ovf_s;
  logic       run_w, run_s;

  int n_chk;
  int n_pass;

  // Model: total increments since clear, per channel.
  longint tot [5];
  longint sh  [5];
  bit     m_run;
  bit     m_ack;

  perf_counter_bank #(
    .N_EV(N_EV), .CNT_W(8), .SAT_MODE(0)
  ) dut_w (
    .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .ev(ev),
    .halt_req(halt_req), .resume(resume), .freeze(freeze),
    .snap_req(snap_req), .snap_ack(ack_w), .rd_sel(rd_sel),
    .rd_data(rd_w), .ovf(ovf_w), .running(run_w)
  );

  perf_counter_bank #(
    .N_EV(N_EV), .CNT_W(8), .SAT_MODE(1)
  ) dut_s (
    .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .ev(ev),
    .halt_req(halt_req), .resume(resume), .freeze(freeze),
    .snap_req(snap_req), .snap_ack(ack_s), .rd_sel(rd_sel),
    .rd_data(rd_s), .ovf(ovf_s), .running(run_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mval(longint t, bit sat);
    longint m;
    if (sat) m = (t > 255) ? 255 : t;
    else     m = t % 256;
    return m[7:0];
  endfunction

  function automatic logic [7:0] mrd(int sel, bit sat);
    if (sel > N_EV) return 8'h00;
    return mval(sh[sel], sat);
  endfunction

  function automatic logic [4:0] movf();
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[k] = (tot[k] > 255);
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      tot[k] = 0;
      sh[k]  = 0;
    end
    m_run = 1'b1;
    m_ack = 1'b0;
  endtask

  task automatic model_clk();
    if (soft_clr) begin
      model_reset();
    end else begin
      m_ack = snap_req;
      if (snap_req) for (int k = 0; k < 5; k++) sh[k] = tot[k];
      if (m_run && !freeze) begin
        if (!halt_req) tot[0]++;
        for (int k = 1; k < 5; k++) if (ev[k-1]) tot[k]++;
      end
      if (m_run && halt_req)      m_run = 1'b0;
      else if (!m_run && resume)  m_run = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic idle();
    soft_clr = 0; ev = 0; halt_req = 0; resume = 0;
    freeze = 0; snap_req = 0; rd_sel = 0;
  endtask

  task automatic do_reset();
    idle();
    clr_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    clr_n = 1'b0;
    #2;
    model_reset();
    n_chk++;
    if (run_w !== 1'b1 || run_s !== 1'b1 || ack_w !== 1'b0 ||
        ack_s !== 1'b0)
      $display("FAIL reset_ctrl run=%b/%b ack=%b/%b want 1/1 0/0",
               run_w, run_s, ack_w, ack_s);
    else n_pass++;
    n_chk++;
    if (ovf_w !== 5'd0 || ovf_s !== 5'd0)
      $display("FAIL reset_ovf got %b/%b want 0", ovf_w, ovf_s);
    else n_pass++;
    for (int s = 0; s < 5; s++) begin
      rd_sel = 3'(s);
      #1;
      n_chk++;
      if (rd_w !== 8'd0 || rd_s !== 8'd0)
        $display("FAIL reset_rd%0d got %0d/%0d want 0", s, rd_w, rd_s);
      else n_pass++;
    end
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic test_cycle_count();
    do_reset();
    repeat (10) step();
    snap();
    rd_sel = 0;
    #1;
    n_chk++;
    if (ack_w !== 1'b1 || ack_s !== 1'b1)
      $display("FAIL c0_ack got %b/%b want 1", ack_w, ack_s);
    else n_pass++;
    n_chk++;
    if (rd_w !== 8'd10 || rd_s !== 8'd10 || rd_w !== mrd(0, 0))
      $display("FAIL c0_ten got %0d/%0d want 10", rd_w, rd_s);
    else n_pass++;
    step();
    n_chk++;
    if (ack_w !== 1'b0 || ack_s !== 1'b0)
      $display("FAIL c0_ack_drop got %b/%b want 0", ack_w, ack_s);
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    ev = 4'b0010;
    repeat (5) step();
    ev = 0;
    halt_req = 1;
    step();
    halt_req = 0;
    ev = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (run_w !== 1'b0 || run_s !== 1'b0)
        $display("FAIL halt_running got %b/%b want 0", run_w, run_s);
      else n_pass++;
      step();
    end
    ev = 0;
    resume = 1;
    step();
    resume = 0;
    n_chk++;
    if (run_w !== 1'b1 || run_s !== 1'b1)
      $display("FAIL resume_running got %b/%b want 1", run_w, run_s);
    else n_pass++;
    snap();
    rd_sel = 2;
    #1;
    n_chk++;
    if (rd_w !== 8'd5 || rd_s !== 8'd5 || rd_w !== mrd(2, 0))
      $display("FAIL halt_e2 got %0d/%0d want 5", rd_w, rd_s);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    ev = 4'b0001;
    repeat (256) step();
    ev = 0;
    snap();
    rd_sel = 1;
    #1;
    n_chk++;
    if (rd_w !== 8'd0 || rd_w !== mrd(1, 0))
      $display("FAIL ovf_wrap_e1 got %0d want 0", rd_w);
    else n_pass++;
    n_chk++;
    if (rd_s !== 8'd255 || rd_s !== mrd(1, 1))
      $display("FAIL ovf_sat_e1 got %0d want 255", rd_s);
    else n_pass++;
    n_chk++;
    if (ovf_w !== 5'b00011 || ovf_s !== 5'b00011)
      $display("FAIL ovf_flags got %b/%b want 00011", ovf_w, ovf_s);
    else n_pass++;
    rd_sel = 0;
    #1;
    n_chk++;
    if (rd_w !== 8'd0 || rd_s !== 8'd255)
      $display("FAIL ovf_c0 got %0d/%0d want 0/255", rd_w, rd_s);
    else n_pass++;
  endtask

  task automatic test_freeze_clear();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      freeze = (i >= 2 && i < 6);
      step();
    end
    freeze = 0;
    snap();
    rd_sel = 0;
    #1;
    n_chk++;
    if (rd_w !== 8'd6 || rd_s !== 8'd6 || rd_w !== mrd(0, 0))
      $display("FAIL freeze_c0 got %0d/%0d want 6", rd_w, rd_s);
    else n_pass++;
    ev = 4'b1111;
    repeat (3) step();
    ev = 0;
    soft_clr = 1;
    snap_req = 1;
    step();
    soft_clr = 0;
    snap_req = 0;
    n_chk++;
    if (ack_w !== 1'b0 || ack_s !== 1'b0 || ovf_w !== 5'd0 ||
        run_w !== 1'b1)
      $display("FAIL clr_ctrl ack=%b/%b ovf=%b run=%b want 0/0 0 1",
               ack_w, ack_s, ovf_w, run_w);
    else n_pass++;
    for (int s = 0; s < 5; s++) begin
      rd_sel = 3'(s);
      #1;
      n_chk++;
      if (rd_w !== 8'd0 || rd_s !== 8'd0)
        $display("FAIL clr_rd%0d got %0d/%0d want 0", s, rd_w, rd_s);
      else n_pass++;
    end
  endtask

  task automatic test_async_clear();
    do_reset();
    ev = 4'b0101;
    repeat (7) step();
    ev = 0;
    snap();
    halt_req = 1;
    step();
    halt_req = 0;
    n_chk++;
    if (run_w !== 1'b0)
      $display("FAIL pre_clr_halt got %b want 0", run_w);
    else n_pass++;
    #3;
    clr_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (run_w !== 1'b1 || run_s !== 1'b1 || ovf_w !== 5'd0)
      $display("FAIL async_ctrl run=%b/%b ovf=%b want 1 0",
               run_w, run_s, ovf_w);
    else n_pass++;
    for (int s = 0; s < 5; s++) begin
      rd_sel = 3'(s);
      #1;
      n_chk++;
      if (rd_w !== 8'd0 || rd_s !== 8'd0)
        $display("FAIL async_rd%0d got %0d/%0d want 0", s, rd_w, rd_s);
      else n_pass++;
    end
    @(negedge clk);
    clr_n = 1'b1;
    rd_sel = 0;
    repeat (3) step();
    snap();
    #1;
    n_chk++;
    if (rd_w !== 8'd3 || run_w !== 1'b1)
      $display("FAIL async_recount got %0d run=%b want 3 1",
               rd_w, run_w);
    else n_pass++;
  endtask

  task automatic test_halt_resume_both();
    do_reset();
    repeat (4) step();
    snap();
    halt_req = 1;
    resume = 1;
    step();
    halt_req = 0;
    resume = 0;
    n_chk++;
    if (run_w !== 1'b0 || run_s !== 1'b0)
      $display("FAIL both_state got %b/%b want 0", run_w, run_s);
    else n_pass++;
    rd_sel = 0;
    #1;
    n_chk++;
    if (rd_w !== 8'd4)
      $display("FAIL both_c0 got %0d want 4", rd_w);
    else n_pass++;
    for (int s = 5; s < 8; s++) begin
      rd_sel = 3'(s);
      #1;
      n_chk++;
      if (rd_w !== 8'd0 || rd_s !== 8'd0)
        $display("FAIL oob_rd%0d got %0d/%0d want 0", s, rd_w, rd_s);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (2) step();
    snap_req = 1;
    rd_sel = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if (ack_w !== 1'b1 || rd_w !== 8'(2 + i))
        $display("FAIL b2b_%0d ack=%b rd=%0d want 1 %0d",
                 i, ack_w, rd_w, 2 + i);
      else n_pass++;
    end
    snap_req = 0;
    step();
    n_chk++;
    if (ack_w !== 1'b0 || ack_s !== 1'b0)
      $display("FAIL b2b_end got %b/%b want 0", ack_w, ack_s);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] e_w, e_s;
    logic [4:0] e_o;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      soft_clr = ($urandom_range(0, 39) == 0);
      halt_req = ($urandom_range(0, 9) == 0);
      resume   = ($urandom_range(0, 4) == 0);
      freeze   = ($urandom_range(0, 4) == 0);
      snap_req = ($urandom_range(0, 2) == 0);
      ev       = 4'($urandom);
      rd_sel   = 3'($urandom_range(0, 7));
      step();
      e_w = mrd(int'(rd_sel), 0);
      e_s = mrd(int'(rd_sel), 1);
      e_o = movf();
      n_chk++;
      if (rd_w !== e_w || rd_s !== e_s)
        $display("FAIL rnd_rd it=%0d sel=%0d got %0d/%0d want %0d/%0d",
                 i, rd_sel, rd_w, rd_s, e_w, e_s);
      else n_pass++;
      n_chk++;
      if (ovf_w !== e_o || ovf_s !== e_o)
        $display("FAIL rnd_ovf it=%0d got %b/%b want %b",
                 i, ovf_w, ovf_s, e_o);
      else n_pass++;
      n_chk++;
      if (ack_w !== m_ack || ack_s !== m_ack ||
          run_w !== m_run || run_s !== m_run)
        $display("FAIL rnd_ctrl it=%0d ack=%b/%b run=%b/%b want %b %b",
                 i, ack_w, ack_s, run_w, run_s, m_ack, m_run);
      else n_pass++;
    end
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clr_n  = 1'b0;
    idle();
    model_reset();
    #3;
    test_reset();
    test_cycle_count();
    test_halt();
    test_overflow();
    test_freeze_clear();
    test_async_clear();
    test_halt_resume_both();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
